imm_decode_buffer: RTL
======================

# imm_decode_buffer

ImmDecodeBuffer is a two-entry elastic buffer between the instruction fetch stage and the immediate path of the 16-bit processor. It accepts one fetched instruction per cycle over a valid/ready handshake. For the entry at its head it presents the decoded fields, plus the immediate in three forms:
- raw 8-bit, which feeds the upper-byte shifter for load-upper instructions;
- 16-bit sign-extended;
- 16-bit zero-extended.

A synchronous flush discards all buffered instructions on branch redirect.

## Interface
Parameters:
- IW, 16, instruction width; fixed at 16, present for readability only.
- IMMW, 8, immediate field width, taken from Instr[IMMW-1:0].

Ports:
- CLK  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous; empties the buffer at the next edge.
- InValid  in  1  fetch presents a valid instruction.
- Instr  in  16  instruction word.
- InReady  out  1  buffer can accept; registered.
- OutValid  out  1  head entry valid; registered.
- OutReady  in  1  downstream consumes the head entry this cycle.
- Opcode  out  4  head Instr[15:12].
- Rd  out  4  head Instr[11:8].
- Imm8  out  8  head Instr[7:0]; drives the upper-byte shifter.
- ImmSExt  out  16  {{8{Instr[7]}}, Instr[7:0]}.
- ImmZExt  out  16  {8'h00, Instr[7:0]}.

## Operation
- Entry format:
  - Only the raw 16-bit instruction is stored.
  - Decoded outputs are combinational from the head entry register.
  - No arithmetic is performed beyond extension.
- A push occurs when InValid && InReady. A pop occurs when OutValid && OutReady.
- States are EMPTY, ONE and TWO, encoded in a 2-bit count.
- EMPTY:
  - push → ONE; the entry is written to the head.
  - no push → stays EMPTY.
- ONE:
  - push and no pop → TWO; the entry is written to the tail.
  - pop and no push → EMPTY.
  - push and pop together → stays ONE; the new entry is written to the head.
  - neither → stays ONE.
- TWO:
  - pop → ONE; the tail moves to the head.
  - InReady is 0, so no push can occur.
- InReady = (next state != TWO), registered. InValid is never dropped while InReady=1.
- OutValid = (state != EMPTY), registered.
- Flush has priority over push and pop in the same cycle:
  - the next state is EMPTY;
  - an instruction offered that cycle is not captured.
- While OutValid=0 the data outputs hold their last values. Downstream ignores them.
- Instr is sampled only on a push and is otherwise don't-care.

## Timing
- Reset (Reset_n=0, asynchronous): state EMPTY; OutValid=0; InReady=1; both entries and all data outputs 0.
- Release of reset is synchronous to CLK. A push is possible on the first edge with Reset_n=1.
- Latency:
  - an instruction pushed at edge N is visible on the outputs with OutValid=1 after edge N.
  - there is no combinational in→out bypass.
- Throughput is one instruction per cycle with OutReady held at 1.
- InReady and OutValid depend only on registered state, so neither handshake has a combinational path.
- Order is preserved: output order equals push order.
- Reset asserted mid-operation discards both entries immediately.

## Structure
- The shared processor package holds:
  - field positions: OPC_MSB=15, OPC_LSB=12, RD_MSB=11, RD_LSB=8, IMM_MSB=7;
  - the state encoding constants EMPTY=0, ONE=1, TWO=2.
- Sub-module ImmExtend is purely combinational: it takes the 8-bit immediate and produces ImmSExt and ImmZExt. It is instantiated once on the head entry.
- Everything else, i.e. control and the two entry registers, lives in ImmDecodeBuffer.

## Test plan
- Reset, then push 16'h3A85 with OutReady=1 → one cycle later:
  - OutValid=1; Opcode=4'h3; Rd=4'hA; Imm8=8'h85;
  - ImmSExt=16'hFF85; ImmZExt=16'h0085;
  - the next cycle OutValid=0.
- OutReady=0, push 16'h1111 then 16'h2222 → after the second edge InReady=0 and Imm8=8'h11. A third offer of 16'h3333 is held, not lost. Raise OutReady → outputs show 16'h2222 next, then 16'h3333.
- Continuous streaming of 16'h0001..16'h0010 with InValid=OutReady=1 → one instruction out per cycle in order; InReady stays 1 throughout.
- Buffer in state TWO (16'hAAAA, 16'hBBBB); assert Flush together with InValid on 16'hCCCC → next cycle OutValid=0 and InReady=1; 16'hCCCC is never output.
- Assert Reset_n=0 mid-stream asynchronously, between clock edges → OutValid drops to 0 and InReady rises to 1 without a clock edge; after release the first push 16'h5F7F gives ImmSExt=16'h007F.
- In state ONE, push and pop in the same cycle → the state stays ONE and the new head is the pushed word.

Source files
------------

// File: rtl/imm_decode_buffer_pkg.sv
// Shared definitions for the immediate decode buffer: instruction field positions
// and the buffer occupancy encoding.
package imm_decode_buffer_pkg;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_decode_buffer_imm_extend.sv
// Purely combinational immediate extension: sign- and zero-extends the raw
// immediate to the full instruction width.
module imm_decode_buffer_imm_extend
    import imm_decode_buffer_pkg::*;
#(
    parameter int unsigned IW   = 16,
    parameter int unsigned IMMW = 8
) (
    input  logic [IMMW-1:0] imm,
    output logic [IW-1:0]   imm_sext,
    output logic [IW-1:0]   imm_zext
);

    assign imm_sext = {{(IW - IMMW){imm[IMMW-1]}}, imm};
    assign imm_zext = {{(IW - IMMW){1'b0}}, imm};

endmodule

// File: rtl/imm_decode_buffer.sv
// Two-entry elastic buffer between fetch and the immediate path; decodes the
// head entry into opcode, destination register and extended immediates.
module imm_decode_buffer
    import imm_decode_buffer_pkg::*;
#(
    parameter int unsigned IW   = 16,
    parameter int unsigned IMMW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [IW-1:0]   instr,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      opcode,
    output logic [3:0]      rd,
    output logic [IMMW-1:0] imm8,
    output logic [IW-1:0]   imm_sext,
    output logic [IW-1:0]   imm_zext
);

    state_e        state_q, state_d;
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic          in_ready_q, out_valid_q;
    logic          push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        head_d  = instr;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d = TWO;
                        tail_d  = instr;
                    end else if (pop && !push) begin
                        state_d = EMPTY;
                    end else if (push && pop) begin
                        head_d = instr;
                    end
                end
                TWO: begin
                    // in_ready is low here, so a pop is the only possible event
                    if (pop) begin
                        state_d = ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign opcode    = head_q[OPC_MSB:OPC_LSB];
    assign rd        = head_q[RD_MSB:RD_LSB];
    assign imm8      = head_q[IMM_MSB:0];

    imm_decode_buffer_imm_extend #(
        .IW   (IW),
        .IMMW (IMMW)
    ) u_imm_extend (
        .imm      (head_q[IMM_MSB:0]),
        .imm_sext (imm_sext),
        .imm_zext (imm_zext)
    );

endmodule
